exception_sequencer: RTL
========================

Name: exception_sequencer

Overview:
Multicycle controller for the processor's exception path. On a qualified exception it saves EPC and records the cause. It then fetches the handler-address byte from the fixed vector location in memory and drives the EX select mux plus PC write so that the PC loads the zero-extended vector. The main control unit stalls while busy is high and resumes in the cycle after done.

Parameters:
MEM_LATENCY, 1, number of wait cycles between driving mem_addr and mem_data_in being valid (legal range 1..7).
EPC_OFFSET, 4, value subtracted from pc_in when saving EPC (PC is already incremented at check time).
VEC_OPCODE, 253, memory byte address of the invalid-opcode vector.
VEC_OVF, 254, memory byte address of the overflow vector.
VEC_DIV0, 255, memory byte address of the divide-by-zero vector.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
exc_check  in  1  from control unit; exception flags are sampled only when this is high.
opcode_exc  in  1  invalid opcode flag.
ovf_exc  in  1  ALU overflow flag.
div0_exc  in  1  divide-by-zero flag.
pc_in  in  32  current PC value.
mem_data_in  in  32  memory read data.
mem_addr  out  32  address for the vector fetch.
mem_read  out  1  memory read request.
ex_control  out  1  EX mux select (0 = PCSource_out, 1 = Mem_out).
pc_write  out  1  PC load enable.
epc_write  out  1  one-cycle pulse when EPC is updated.
epc_out  out  32  saved exception PC.
cause  out  2  00 none, 01 opcode, 10 overflow, 11 div0.
exc_vector  out  32  registered {24'b0, mem_data_in[7:0]}.
busy  out  1  high from the cycle after acceptance until done.
done  out  1  one-cycle pulse coinciding with pc_write.

Behaviour:
- Reset: state = IDLE. All outputs are 0, including epc_out, cause, exc_vector and mem_addr. Reset overrides any in-flight sequence; no PC write occurs after reset.
- IDLE: an exception is accepted when exc_check is high and any flag is high. Priority is opcode > overflow > div0, and only one cause is recorded.
- On acceptance (edge E): epc_out <= pc_in - EPC_OFFSET (mod 2^32), cause latched, mem_addr <= the selected VEC_*, next state = SAVE.
- SAVE (1 cycle): epc_write = 1, mem_read = 1, busy = 1. Wait counter is loaded with MEM_LATENCY. Next state = WAIT.
- WAIT: mem_read = 1, busy = 1, counter decrements each cycle. When the counter reaches 1, exc_vector is captured from mem_data_in on that edge and next state = LOAD.
- LOAD (1 cycle): ex_control = 1, pc_write = 1, done = 1, busy = 1. Next state = IDLE.
- Latency with MEM_LATENCY = 1: acceptance edge E, then SAVE, WAIT and LOAD each last one cycle. done is high in the 3rd cycle after E; IDLE resumes on the 4th.
- In IDLE and SAVE/WAIT, ex_control = 0 and pc_write = 0; the control unit owns the PC.
- Flags arriving while not in IDLE are ignored: not queued, and cause does not change.
- exc_check high with no flags set: no action.
- Flags high while exc_check is low: no action.
- epc_out, cause and exc_vector hold their values after done until the next acceptance or reset.
- mem_addr holds its value until the next acceptance.
- Upper 24 bits of mem_data_in are ignored.

Test Plan:
- Reset then idle: reset for 2 cycles -> all outputs 0; exc_check = 1 with no flags -> state stays IDLE and busy = 0.
- Overflow: exc_check = 1, ovf_exc = 1, pc_in = 0x00000104, mem[254] byte = 0x80 -> cause = 10, mem_addr = 254, epc_write pulse, epc_out = 0x00000100; 3 cycles later pc_write = ex_control = done = 1, exc_vector = 0x00000080.
- Priority: opcode_exc, ovf_exc and div0_exc all high -> cause = 01, mem_addr = 253; a second flag pulse while busy leaves cause = 01.
- Latency: MEM_LATENCY = 3, div0_exc -> mem_read held 4 cycles (SAVE + 3 WAIT); done on the 5th cycle after acceptance; mem_data_in = 0xFFFFFF40 -> exc_vector = 0x00000040.
- Reset mid-sequence: assert reset in WAIT -> next cycle all outputs 0, and no pc_write pulse ever occurs.
- EPC wrap: pc_in = 0x00000002 with overflow -> epc_out = 0xFFFFFFFE.

Source files
------------

// File: rtl/exception_sequencer.sv
// Exception-path sequencer: saves EPC and cause, fetches the handler vector byte
// from memory, then loads it into the PC through the EX mux.
//
// state  | meaning
// S_IDLE | waiting for a qualified exception; control unit owns the PC
// S_SAVE | EPC/cause just latched, epc_write pulse, vector read starts
// S_WAIT | vector read in flight, counting down MEM_LATENCY
// S_LOAD | PC loads the zero-extended vector, done pulse
module exception_sequencer #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned EPC_OFFSET  = 4,
    parameter int unsigned VEC_OPCODE  = 253,
    parameter int unsigned VEC_OVF     = 254,
    parameter int unsigned VEC_DIV0    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_check,
    input  logic        opcode_exc,
    input  logic        ovf_exc,
    input  logic        div0_exc,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        ex_control,
    output logic        pc_write,
    output logic        epc_write,
    output logic [31:0] epc_out,
    output logic [1:0]  cause,
    output logic [31:0] exc_vector,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SAVE = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] vec_q, vec_d;
    logic        accept;

    // Only the low byte of the read word carries the handler address.
    logic unused_mem_hi;
    assign unused_mem_hi = ^mem_data_in[31:8];

    assign accept = exc_check && (opcode_exc || ovf_exc || div0_exc);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        mem_addr_d = mem_addr_q;
        vec_d      = vec_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    epc_d   = pc_in - 32'(EPC_OFFSET);
                    state_d = S_SAVE;
                    if (opcode_exc) begin
                        cause_d    = 2'b01;
                        mem_addr_d = 32'(VEC_OPCODE);
                    end else if (ovf_exc) begin
                        cause_d    = 2'b10;
                        mem_addr_d = 32'(VEC_OVF);
                    end else begin
                        cause_d    = 2'b11;
                        mem_addr_d = 32'(VEC_DIV0);
                    end
                end
            end
            S_SAVE: begin
                cnt_d   = 3'(MEM_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A count of 0 can only come from an out-of-range parameter; finish anyway.
                if (cnt_q <= 3'd1) begin
                    vec_d   = {24'b0, mem_data_in[7:0]};
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            epc_q      <= 32'd0;
            cause_q    <= 2'b00;
            mem_addr_q <= 32'd0;
            vec_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            mem_addr_q <= mem_addr_d;
            vec_q      <= vec_d;
        end
    end

    assign epc_write  = (state_q == S_SAVE);
    assign mem_read   = (state_q == S_SAVE) || (state_q == S_WAIT);
    assign busy       = (state_q != S_IDLE);
    assign ex_control = (state_q == S_LOAD);
    assign pc_write   = (state_q == S_LOAD);
    assign done       = (state_q == S_LOAD);
    assign epc_out    = epc_q;
    assign cause      = cause_q;
    assign mem_addr   = mem_addr_q;
    assign exc_vector = vec_q;

endmodule
